// File: rtl/trng_pkg.sv
// Shared encodings for the TRNG sequencing controller.
package trng_pkg;

  typedef enum logic [1:0] {
    OP_INST   = 2'b00,
    OP_RESEED = 2'b01,
    OP_GEN    = 2'b10,
    OP_RSVD   = 2'b11
  } op_t;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_CLEAR      = 3'd1,
    ST_HASH_START = 3'd2,
    ST_HASH_WAIT  = 3'd3,
    ST_CAPTURE    = 3'd4,
    ST_DONE       = 3'd5,
    ST_ERR        = 3'd6
  } state_t;

  // One-hot decode of a state-register index (up to 8 registers).
  function automatic logic [7:0] onehot8(input logic [2:0] idx);
    onehot8 = 8'b1 << idx;
  endfunction

endpackage

// File: rtl/trng_seq_controller_if.sv
// Host request/status and hash-datapath control bundle of the TRNG sequencer.
interface trng_seq_controller_if
  import trng_pkg::*;
#(
  parameter int NUM_REGS = 2,
  parameter int CNT_W    = 8
) ();

  logic                TRNG_Go;
  op_t                 Op_Type;
  logic [CNT_W-1:0]    Num_Blocks;
  logic                Hash_done;

  logic                Hash_Go;
  logic                mux1_sel;
  logic                mux2_sel;
  logic [NUM_REGS-1:0] rst_reg;
  logic [NUM_REGS-1:0] en_reg;
  logic                Out_Valid;
  logic                TRNG_Busy;
  logic                TRNG_Done;
  logic                TRNG_Err;
  logic                Reseed_Req;

  // Controller view.
  modport slave (
    input  TRNG_Go, Op_Type, Num_Blocks, Hash_done,
    output Hash_Go, mux1_sel, mux2_sel, rst_reg, en_reg, Out_Valid,
           TRNG_Busy, TRNG_Done, TRNG_Err, Reseed_Req
  );

  // Host plus hash-core view.
  modport master (
    output TRNG_Go, Op_Type, Num_Blocks, Hash_done,
    input  Hash_Go, mux1_sel, mux2_sel, rst_reg, en_reg, Out_Valid,
           TRNG_Busy, TRNG_Done, TRNG_Err, Reseed_Req
  );

endinterface

// File: rtl/trng_done_sync.sv
// Hash completion detector: finishes only after Hash_done is seen low, then high.
module trng_done_sync (
  input  logic clk,
  input  logic Resetn,
  input  logic clr,
  input  logic watch,
  input  logic hash_done,
  output logic done
);

  logic seen_low;

  // Remember that the hash core dropped its done level during this wait.
  always_ff @(posedge clk or negedge Resetn) begin
    if (!Resetn) begin
      seen_low <= 1'b0;
    end else if (clr) begin
      seen_low <= 1'b0;
    end else if (watch && !hash_done) begin
      seen_low <= 1'b1;
    end
  end

  assign done = watch && seen_low && hash_done;

endmodule

// File: rtl/trng_seq_controller.sv
// TRNG sequencer: drives the hash datapath for instantiate, reseed and generate.
module trng_seq_controller
  import trng_pkg::*;
#(
  parameter int NUM_REGS = 2,
  parameter int MAX_GEN  = 16,
  parameter int CNT_W    = 8
) (
  input logic                  clk,
  input logic                  Resetn,
  trng_seq_controller_if.slave bus
);

  localparam logic [CNT_W-1:0]    MAX_GEN_C = CNT_W'(MAX_GEN);
  localparam logic [2:0]          LAST_IDX  = 3'(NUM_REGS - 1);
  localparam logic [NUM_REGS-1:0] EN_LAST   = NUM_REGS'(onehot8(LAST_IDX));

  state_t              state;
  op_t                 op_q;
  logic [CNT_W-1:0]    nblk_q;
  logic [CNT_W-1:0]    blk_cnt;
  logic [CNT_W-1:0]    blk_inc;
  logic [CNT_W-1:0]    reseed_cnt;
  logic [2:0]          pass_idx;
  logic                inst_q;
  logic                hash_fin;

  logic                hash_go_q;
  logic                mux1_q;
  logic                mux2_q;
  logic [NUM_REGS-1:0] rst_q;
  logic [NUM_REGS-1:0] en_q;
  logic                ov_q;
  logic                busy_q;
  logic                done_q;
  logic                err_q;
  logic                rreq_q;

  assign blk_inc = blk_cnt + CNT_W'(1);

  trng_done_sync u_done_sync (
    .clk       (clk),
    .Resetn    (Resetn),
    .clr       (state == ST_HASH_START),
    .watch     (state == ST_HASH_WAIT),
    .hash_done (bus.Hash_done),
    .done      (hash_fin)
  );

  // Sequencer FSM; each output is set on entry to the state that owns it.
  always_ff @(posedge clk or negedge Resetn) begin
    if (!Resetn) begin
      state      <= ST_IDLE;
      op_q       <= OP_INST;
      nblk_q     <= '0;
      blk_cnt    <= '0;
      reseed_cnt <= '0;
      pass_idx   <= '0;
      inst_q     <= 1'b0;
      hash_go_q  <= 1'b0;
      mux1_q     <= 1'b0;
      mux2_q     <= 1'b0;
      rst_q      <= '0;
      en_q       <= '0;
      ov_q       <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      rreq_q     <= 1'b0;
    end else begin
      hash_go_q <= 1'b0;
      rst_q     <= '0;
      en_q      <= '0;
      ov_q      <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (bus.TRNG_Go) begin
            op_q     <= bus.Op_Type;
            nblk_q   <= bus.Num_Blocks;
            blk_cnt  <= '0;
            pass_idx <= '0;
            busy_q   <= 1'b1;
            case (bus.Op_Type)
              OP_INST: begin
                mux1_q <= 1'b0;
                mux2_q <= 1'b0;
                rst_q  <= '1;
                state  <= ST_CLEAR;
              end
              OP_RESEED: begin
                if (!inst_q) begin
                  err_q <= 1'b1;
                  state <= ST_ERR;
                end else begin
                  mux1_q    <= 1'b0;
                  mux2_q    <= 1'b1;
                  hash_go_q <= 1'b1;
                  state     <= ST_HASH_START;
                end
              end
              OP_GEN: begin
                if (!inst_q || reseed_cnt == MAX_GEN_C) begin
                  err_q <= 1'b1;
                  state <= ST_ERR;
                end else if (bus.Num_Blocks == '0) begin
                  done_q <= 1'b1;
                  state  <= ST_DONE;
                end else begin
                  mux1_q    <= 1'b1;
                  mux2_q    <= 1'b0;
                  hash_go_q <= 1'b1;
                  state     <= ST_HASH_START;
                end
              end
              default: begin
                err_q <= 1'b1;
                state <= ST_ERR;
              end
            endcase
          end
        end
        ST_CLEAR: begin
          reseed_cnt <= '0;
          hash_go_q  <= 1'b1;
          state      <= ST_HASH_START;
        end
        ST_HASH_START: begin
          state <= ST_HASH_WAIT;
        end
        ST_HASH_WAIT: begin
          if (hash_fin) begin
            state <= ST_CAPTURE;
            if (op_q == OP_GEN) begin
              en_q       <= EN_LAST;
              ov_q       <= 1'b1;
              reseed_cnt <= reseed_cnt + CNT_W'(1);
            end else begin
              en_q <= NUM_REGS'(onehot8(pass_idx));
            end
          end
        end
        ST_CAPTURE: begin
          if (op_q == OP_GEN) begin
            // reseed_cnt already holds this block's increment here.
            blk_cnt <= blk_inc;
            if (reseed_cnt == MAX_GEN_C) begin
              rreq_q <= 1'b1;
            end
            if (blk_inc == nblk_q || reseed_cnt == MAX_GEN_C) begin
              done_q <= 1'b1;
              state  <= ST_DONE;
            end else begin
              hash_go_q <= 1'b1;
              state     <= ST_HASH_START;
            end
          end else if (pass_idx == LAST_IDX) begin
            inst_q     <= 1'b1;
            reseed_cnt <= '0;
            rreq_q     <= 1'b0;
            done_q     <= 1'b1;
            state      <= ST_DONE;
          end else begin
            pass_idx  <= pass_idx + 3'd1;
            hash_go_q <= 1'b1;
            state     <= ST_HASH_START;
          end
        end
        ST_DONE: begin
          busy_q <= 1'b0;
          state  <= ST_IDLE;
        end
        ST_ERR: begin
          busy_q <= 1'b0;
          state  <= ST_IDLE;
        end
        default: begin
          busy_q <= 1'b0;
          state  <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.Hash_Go    = hash_go_q;
  assign bus.mux1_sel   = mux1_q;
  assign bus.mux2_sel   = mux2_q;
  assign bus.rst_reg    = rst_q;
  assign bus.en_reg     = en_q;
  assign bus.Out_Valid  = ov_q;
  assign bus.TRNG_Busy  = busy_q;
  assign bus.TRNG_Done  = done_q;
  assign bus.TRNG_Err   = err_q;
  assign bus.Reseed_Req = rreq_q;

endmodule

// File: tb/tb_trng_seq_controller.sv
// Directed bench for trng_seq_controller with a simple hash-core responder.
module tb_trng_seq_controller;
  import trng_pkg::*;

  localparam int NR = 2;
  localparam int MG = 4;
  localparam int CW = 8;

  logic clk = 1'b0;
  logic Resetn = 1'b1;
  logic hd = 1'b1;
  int   cyc = 0;

  int n_checks = 0;
  int n_errors = 0;

  trng_seq_controller_if #(.NUM_REGS(NR), .CNT_W(CW)) bus ();

  trng_seq_controller #(.NUM_REGS(NR), .MAX_GEN(MG), .CNT_W(CW)) dut (
    .clk    (clk),
    .Resetn (Resetn),
    .bus    (bus)
  );

  assign bus.Hash_done = hd;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // Hash core: after Hash_Go, holds done high hm_pre cycles, low hm_lo cycles.
  int hm_pre = 0;
  int hm_lo = 2;
  int hm_phase = 0;
  int hm_cnt = 0;
  int hm_fall = 0;
  always @(negedge clk) begin
    if (!Resetn) begin
      hd = 1'b1;
      hm_phase = 0;
    end else begin
      case (hm_phase)
        0: if (bus.Hash_Go) begin
          if (hm_pre == 0) begin
            hd = 1'b0; hm_fall = cyc; hm_cnt = hm_lo; hm_phase = 2;
          end else begin
            hm_cnt = hm_pre; hm_phase = 1;
          end
        end
        1: begin
          hm_cnt--;
          if (hm_cnt == 0) begin
            hd = 1'b0; hm_fall = cyc; hm_cnt = hm_lo; hm_phase = 2;
          end
        end
        default: begin
          hm_cnt--;
          if (hm_cnt == 0) begin
            hd = 1'b1; hm_phase = 0;
          end
        end
      endcase
    end
  end

  // Output monitor: pulse counters and a log of every register load.
  int n_go = 0, n_ov = 0, n_ov_bad = 0, n_done = 0, n_err = 0, n_rst = 0;
  logic [NR-1:0] last_rst = '0;
  logic [NR-1:0] en_log[$];
  logic          mux1_log[$];
  logic          mux2_log[$];
  int            cap_log[$];
  always @(negedge clk) begin
    if (Resetn) begin
      if (bus.Hash_Go) n_go++;
      if (bus.Out_Valid) begin
        n_ov++;
        if (bus.en_reg != 2'b10 || !bus.mux1_sel || bus.mux2_sel) n_ov_bad++;
      end
      if (bus.TRNG_Done) n_done++;
      if (bus.TRNG_Err) n_err++;
      if (bus.rst_reg != '0) begin
        n_rst++;
        last_rst = bus.rst_reg;
      end
      if (bus.en_reg != '0) begin
        en_log.push_back(bus.en_reg);
        mux1_log.push_back(bus.mux1_sel);
        mux2_log.push_back(bus.mux2_sel);
        cap_log.push_back(cyc);
      end
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] outs_vec();
    return 32'({bus.Hash_Go, bus.mux1_sel, bus.mux2_sel, bus.rst_reg, bus.en_reg,
                bus.Out_Valid, bus.TRNG_Busy, bus.TRNG_Done, bus.TRNG_Err, bus.Reseed_Req});
  endfunction

  int s_go, s_ov, s_ovbad, s_done, s_err, s_rst, s_en;

  task automatic snap();
    s_go = n_go; s_ov = n_ov; s_ovbad = n_ov_bad; s_done = n_done;
    s_err = n_err; s_rst = n_rst; s_en = en_log.size();
  endtask

  // Issue one request and wait (bounded) for the controller to go idle.
  task automatic run_op(input op_t op, input int nb, input bit poke, input string tag);
    bit fin;
    snap();
    @(negedge clk);
    bus.TRNG_Go = 1'b1; bus.Op_Type = op; bus.Num_Blocks = CW'(nb);
    @(negedge clk);
    bus.TRNG_Go = 1'b0;
    check_eq({tag, "_busy"}, 32'(bus.TRNG_Busy), 1);
    fin = 1'b0;
    for (int i = 0; i < 400 && !fin; i++) begin
      @(negedge clk);
      if (poke) begin
        bus.TRNG_Go = (i == 3);
        if (i == 3) bus.Op_Type = OP_INST;
      end
      if (!bus.TRNG_Busy) fin = 1'b1;
    end
    bus.TRNG_Go = 1'b0;
    check_eq({tag, "_finished"}, 32'(fin), 1);
  endtask

  initial begin
    bus.TRNG_Go = 1'b0;
    bus.Op_Type = OP_INST;
    bus.Num_Blocks = '0;
    #1 Resetn = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("reset_outs", outs_vec(), 0);
    Resetn = 1'b1;
    repeat (2) @(negedge clk);

    // Requests refused before instantiation, and the reserved op.
    run_op(OP_GEN, 2, 1'b0, "gen_uninst");
    check_eq("gen_uninst_err", n_err - s_err, 1);
    check_eq("gen_uninst_go", n_go - s_go, 0);
    run_op(OP_RSVD, 1, 1'b0, "op11");
    check_eq("op11_err", n_err - s_err, 1);
    check_eq("op11_go", n_go - s_go, 0);
    check_eq("op11_done", n_done - s_done, 0);
    run_op(OP_RESEED, 0, 1'b0, "rsd_uninst");
    check_eq("rsd_uninst_err", n_err - s_err, 1);

    // Instantiate.
    run_op(OP_INST, 0, 1'b0, "inst");
    check_eq("inst_rst_cycles", n_rst - s_rst, 1);
    check_eq("inst_rst_val", 32'(last_rst), 3);
    check_eq("inst_go", n_go - s_go, 2);
    check_eq("inst_loads", en_log.size() - s_en, 2);
    check_eq("inst_en0", 32'(en_log[s_en]), 1);
    check_eq("inst_en1", 32'(en_log[s_en+1]), 2);
    check_eq("inst_mux1", 32'({mux1_log[s_en], mux1_log[s_en+1]}), 0);
    check_eq("inst_mux2", 32'({mux2_log[s_en], mux2_log[s_en+1]}), 0);
    check_eq("inst_done", n_done - s_done, 1);
    check_eq("inst_err", n_err - s_err, 0);

    // Generate 3 blocks; a stray Go mid-run must be ignored.
    run_op(OP_GEN, 3, 1'b1, "gen3");
    check_eq("gen3_ov", n_ov - s_ov, 3);
    check_eq("gen3_ov_bad", n_ov_bad - s_ovbad, 0);
    check_eq("gen3_go", n_go - s_go, 3);
    check_eq("gen3_no_clear", n_rst - s_rst, 0);
    check_eq("gen3_done", n_done - s_done, 1);
    check_eq("gen3_rreq", 32'(bus.Reseed_Req), 0);

    // Zero-block generate.
    run_op(OP_GEN, 0, 1'b0, "gen0");
    check_eq("gen0_done", n_done - s_done, 1);
    check_eq("gen0_go", n_go - s_go, 0);
    check_eq("gen0_ov", n_ov - s_ov, 0);

    // Reseed clears the counter.
    run_op(OP_RESEED, 0, 1'b0, "rsd1");
    check_eq("rsd1_go", n_go - s_go, 2);
    check_eq("rsd1_en0", 32'(en_log[s_en]), 1);
    check_eq("rsd1_en1", 32'(en_log[s_en+1]), 2);
    check_eq("rsd1_mux2", 32'({mux2_log[s_en], mux2_log[s_en+1]}), 3);
    check_eq("rsd1_mux1", 32'({mux1_log[s_en], mux1_log[s_en+1]}), 0);
    check_eq("rsd1_done", n_done - s_done, 1);

    // Generate 6 with MAX_GEN=4: stops after 4.
    run_op(OP_GEN, 6, 1'b0, "gen6");
    check_eq("gen6_ov", n_ov - s_ov, 4);
    check_eq("gen6_go", n_go - s_go, 4);
    check_eq("gen6_done", n_done - s_done, 1);
    check_eq("gen6_rreq", 32'(bus.Reseed_Req), 1);

    run_op(OP_GEN, 1, 1'b0, "gen_exh");
    check_eq("gen_exh_err", n_err - s_err, 1);
    check_eq("gen_exh_go", n_go - s_go, 0);
    check_eq("gen_exh_rreq", 32'(bus.Reseed_Req), 1);

    run_op(OP_RESEED, 0, 1'b0, "rsd2");
    check_eq("rsd2_mux2", 32'({mux2_log[s_en], mux2_log[s_en+1]}), 3);
    check_eq("rsd2_done", n_done - s_done, 1);
    check_eq("rsd2_rreq", 32'(bus.Reseed_Req), 0);

    // Stale high Hash_done: capture only after the low-then-high sequence.
    hm_pre = 4; hm_lo = 3;
    run_op(OP_GEN, 1, 1'b0, "stale");
    check_eq("stale_ov", n_ov - s_ov, 1);
    check_eq("stale_cap_after_fall", 32'(cap_log[s_en] > hm_fall), 1);
    check_eq("stale_cap_gap", 32'(cap_log[s_en] - hm_fall >= hm_lo), 1);

    // Reset while waiting on the hash core.
    hm_pre = 0; hm_lo = 20;
    @(negedge clk);
    bus.TRNG_Go = 1'b1; bus.Op_Type = OP_GEN; bus.Num_Blocks = CW'(2);
    @(negedge clk);
    bus.TRNG_Go = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("wait_busy", 32'(bus.TRNG_Busy), 1);
    check_eq("wait_mux1", 32'(bus.mux1_sel), 1);
    #2 Resetn = 1'b0;
    #1 check_eq("midrst_outs", outs_vec(), 0);
    repeat (2) @(negedge clk);
    Resetn = 1'b1;
    hm_lo = 3;
    repeat (2) @(negedge clk);
    run_op(OP_GEN, 1, 1'b0, "post_rst");
    check_eq("post_rst_err", n_err - s_err, 1);
    check_eq("post_rst_go", n_go - s_go, 0);
    check_eq("post_rst_rreq", 32'(bus.Reseed_Req), 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
